// File: rtl/button_reader.sv
// button_reader: debounced four-button reader with a one-entry event register; `BUTTON_READER_RELEASE_EVENTS_EN enables release events
module button_reader #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       NOTRESET,
  input  logic [3:0] BUTTONS,
  input  logic       EVENT_ACK,
  output logic [3:0] LEVEL,
  output logic       EVENT_VALID,
  output logic [1:0] EVENT_BUTTON,
  output logic       EVENT_RELEASE,
  output logic       OVERFLOW
);
  logic [3:0] s1, s2, db_edge, set, clr, pend;
  logic [DEBOUNCE_BITS-1:0] cnt [4];
  logic [DEBOUNCE_BITS-1:0] cnt_nx [4];
  logic [1:0] sel;
  logic load;
  // two-flop synchroniser per pin; s2 is the clean sampled level
  always_ff @(posedge clk or posedge NOTRESET)
    if (NOTRESET) {s2, s1} <= '0;
    else {s2, s1} <= {s1, BUTTONS};
  // a mismatch that survives a full counter run is a debounced edge; any agreement restarts the count
  always_comb begin
    cnt_nx = cnt;
    db_edge = '0;
    for (int i = 0; i < 4; i++) begin
      db_edge[i] = s2[i] != LEVEL[i] && &cnt[i];
      cnt_nx[i] = s2[i] == LEVEL[i] || db_edge[i] ? '0 : cnt[i] + DEBOUNCE_BITS'(1);
    end
  end
  // debounce counters and filtered levels; an edge always flips the level
  always_ff @(posedge clk or posedge NOTRESET)
    if (NOTRESET) begin
      cnt <= '{default: '0};
      LEVEL <= '0;
    end else begin
      cnt <= cnt_nx;
      LEVEL <= LEVEL ^ db_edge;
    end
`ifdef BUTTON_READER_RELEASE_EVENTS_EN
  assign set = db_edge;
`else
  assign set = db_edge & s2;
`endif
  assign load = (!EVENT_VALID || EVENT_ACK) && |pend;
  assign sel = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
  assign clr = load ? 4'b0001 << sel : 4'b0000;
  // pending bits feed the event register lowest index first; a new edge on a still-pending button overflows
  always_ff @(posedge clk or posedge NOTRESET)
    if (NOTRESET) begin
      pend <= '0;
      EVENT_VALID <= 1'b0;
      EVENT_BUTTON <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set;
      OVERFLOW <= OVERFLOW || (|(set & pend & ~clr));
      if (load) begin
        EVENT_VALID <= 1'b1;
        EVENT_BUTTON <= sel;
      end else if (EVENT_ACK) EVENT_VALID <= 1'b0;
    end
`ifdef BUTTON_READER_RELEASE_EVENTS_EN
  logic [3:0] ptype;
  // edge type per pending button, newest edge wins; copied out on load
  always_ff @(posedge clk or posedge NOTRESET)
    if (NOTRESET) begin
      ptype <= '0;
      EVENT_RELEASE <= 1'b0;
    end else begin
      ptype <= (ptype & ~set) | (set & ~s2);
      if (load) EVENT_RELEASE <= ptype[sel];
    end
`else
  assign EVENT_RELEASE = 1'b0;
`endif
endmodule

// File: doc/button_reader.md
# button_reader

Debounced input reader for the board's four push-buttons. It is the input-side counterpart of the counter-driven LED outputs. The block synchronises each raw button pin, filters contact bounce with a per-button counter, and presents clean levels plus a one-entry event register with a valid/ack handshake. Downstream logic consumes press/release events without dropping simultaneous edges.

## Interface
- DEBOUNCE_BITS, 16, debounce counter width; an input must hold a new level for 2^DEBOUNCE_BITS consecutive cycles (65536 ≈ 5.5 ms at 12 MHz).
- clk  input  1  sole clock, rising edge.
- NOTRESET  input  1  reset: asynchronous, active-high (despite the name). High clears all state.
- BUTTONS  input  4  raw button pins, active-high, asynchronous to clk.
- EVENT_ACK  input  1  consumer accepts the current event.
- LEVEL  output  4  debounced, registered button levels.
- EVENT_VALID  output  1  event register holds an unconsumed event.
- EVENT_BUTTON  output  2  index of the button that generated the event.
- EVENT_RELEASE  output  1  0 = press (0→1 edge), 1 = release (1→0 edge).
- OVERFLOW  output  1  sticky flag: an event was overwritten before it was consumed.

## Operation
- **Reset values (all outputs and state zero):**
  - Sync flops, counters, LEVEL and the pending bits are 0.
  - EVENT_VALID, EVENT_BUTTON, EVENT_RELEASE and OVERFLOW are 0.
  - Reset is asynchronous and may assert mid-debounce or mid-handshake; all progress is discarded.
- **Synchroniser:** each pin passes through two flops. S[i] is the second flop.
- **Debounce, per button i, with counter CNT[i] of DEBOUNCE_BITS bits:**
  - If S[i] == LEVEL[i]: CNT[i] <= 0.
  - Else if CNT[i] == all-ones: LEVEL[i] <= S[i], CNT[i] <= 0, and a debounced edge is raised.
  - Else: CNT[i] <= CNT[i] + 1.
  - A glitch shorter than 2^DEBOUNCE_BITS cycles returns CNT to 0. The counter never wraps.
- **Pending store, per button:** one bit PEND[i] and one type bit PTYPE[i].
  - A debounced edge sets PEND[i] and writes PTYPE[i] (1 = release).
  - If PEND[i] is already set and is not being loaded this cycle: OVERFLOW <= 1, and PTYPE is overwritten with the newer edge.
  - If a set and a load-clear of PEND[i] happen in the same cycle, the set wins and no overflow is raised.
- **Event register:**
  - Load condition: (!EVENT_VALID || EVENT_ACK) and any PEND bit set.
  - On load, select the lowest-index pending button, copy its index and PTYPE to EVENT_BUTTON/EVENT_RELEASE, set EVENT_VALID, and clear that PEND bit.
  - If EVENT_ACK is high and nothing is pending, EVENT_VALID <= 0.
  - EVENT_ACK while EVENT_VALID is low is ignored.
  - EVENT_BUTTON and EVENT_RELEASE stay stable while EVENT_VALID is high and not acked.
- **OVERFLOW** is cleared only by reset.

## Timing
- Pin change to LEVEL update: 2 sync cycles + 2^DEBOUNCE_BITS cycles. Example: pin rises before edge 0, S rises at edge 2, LEVEL rises at edge 2+2^N.
- LEVEL and PEND update on the same edge. EVENT_VALID rises one edge later, provided the register is empty or being acked.
- Back-to-back: an ack in cycle k with another event pending loads the next event at edge k+1. EVENT_VALID stays high, giving one event per cycle.
- Simultaneous edges on several buttons are reported one per cycle, in ascending index order.
- No combinational path from any input to any output.

## Configuration
- **BUTTON_READER_RELEASE_EVENTS_EN**
  - Defined: both press and release edges generate events, as described above.
  - Undefined: only press edges set PEND. EVENT_RELEASE is tied to 0 and PTYPE is not implemented. LEVEL still tracks both directions.

## Test plan
All scenarios run with DEBOUNCE_BITS=4 (16-cycle debounce).
- **Reset hold:** BUTTONS=4'b1111 held through reset release.
  - LEVEL=4'b1111 at edge 18.
  - Four press events for buttons 0,1,2,3 on successive cycles when EVENT_ACK is held at 1.
- **Bounce:** BUTTON1 toggles every 5 cycles for 40 cycles, then holds 1.
  - No LEVEL change during the toggling.
  - LEVEL[1] rises 18 cycles after the final rise.
  - Exactly one event {BUTTON=1, RELEASE=0}.
- **Handshake stall:** press button 2 with EVENT_ACK=0 for 50 cycles.
  - EVENT_VALID stays high with constant fields.
  - Assert ACK for one cycle: EVENT_VALID drops the next edge.
- **Overflow:** press then release button 0, more than 18 cycles apart, with ACK=0; press button 3 first so it occupies the register.
  - Releasing button 0 while its press is still pending sets OVERFLOW=1.
  - Button 0 then reports a release event (with the macro defined).
- **Reset mid-debounce:** assert NOTRESET at cycle 10 of a 16-cycle debounce.
  - All outputs read 0 immediately (asynchronously).
  - After release, the debounce restarts from zero.
- **Macro off:** press and release button 1.
  - Only one event, with EVENT_RELEASE=0.
  - LEVEL[1] returns to 0.
